// File: rtl/mdio_responder_if.sv
// MDIO responder signal bundle: line sample/drive plus register-file side-band outputs.
// The master modport is the controller/bench side; the slave modport is the responder.
interface mdio_responder_if;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic [15:0] status_i;
    logic [15:0] ctrl_o;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        soft_rst_o;

    modport master (
        output mdio_i, status_i,
        input  mdio_o, mdio_oe, ctrl_o, wr_strobe, wr_addr, wr_data, soft_rst_o
    );

    modport slave (
        input  mdio_i, status_i,
        output mdio_o, mdio_oe, ctrl_o, wr_strobe, wr_addr, wr_data, soft_rst_o
    );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder clocked by MDC: decodes frames for PHY_ADDR,
// serves a 32 x 16-bit register file and drives read data during the read data phase.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter logic [15:0] REG0_RST     = 16'h3100,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1550
) (
    input logic             clk,
    input logic             rst,
    mdio_responder_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle, StSt, StOp, StPhyad, StRegad, StTa, StWrData, StRdData, StSkip
    } state_e;

    localparam logic [5:0] PreSat = 6'(PREAMBLE_LEN);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  pre_q, pre_d;
    logic [15:0] shift_q, shift_d;
    logic        is_read_q, is_read_d;
    logic        phy_match_q, phy_match_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        soft_rst_q, soft_rst_d;
    logic [15:0] regs_q [32];
    logic        reg_we;
    logic [15:0] reg_wval;
    logic [4:0]  regad;
    logic [15:0] rd_val;
    logic [15:0] wdata;

    // Register address completes on the same edge that samples its last bit.
    assign regad = {shift_q[3:0], bus.mdio_i};
    assign wdata = {shift_q[14:0], bus.mdio_i};

    always_comb begin
        case (regad)
            5'd1:    rd_val = bus.status_i;
            5'd2:    rd_val = PHY_ID1;
            5'd3:    rd_val = PHY_ID2;
            default: rd_val = regs_q[regad];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        shift_d     = shift_q;
        is_read_d   = is_read_q;
        phy_match_d = phy_match_q;
        reg_addr_d  = reg_addr_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        soft_rst_d  = 1'b0;
        reg_we      = 1'b0;
        reg_wval    = wdata;
        unique case (state_q)
            StIdle: begin
                if (bus.mdio_i) begin
                    if (pre_q != PreSat) pre_d = pre_q + 6'd1;
                end else if (pre_q == PreSat) begin
                    state_d = StSt;
                    pre_d   = '0;
                end else begin
                    pre_d = '0;
                end
            end
            StSt: begin
                cnt_d   = '0;
                state_d = bus.mdio_i ? StOp : StIdle;
            end
            StOp: begin
                shift_d = {shift_q[14:0], bus.mdio_i};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd1) begin
                    cnt_d     = '0;
                    is_read_d = (shift_q[0] && !bus.mdio_i);
                    state_d   = (shift_q[0] != bus.mdio_i) ? StPhyad : StIdle;
                end
            end
            StPhyad: begin
                shift_d = {shift_q[14:0], bus.mdio_i};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd4) begin
                    cnt_d       = '0;
                    phy_match_d = (regad == PHY_ADDR);
                    state_d     = StRegad;
                end
            end
            StRegad: begin
                shift_d = {shift_q[14:0], bus.mdio_i};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd4) begin
                    cnt_d      = '0;
                    reg_addr_d = regad;
                    state_d    = phy_match_q ? StTa : StSkip;
                    if (is_read_q) shift_d = rd_val;
                end
            end
            StTa: begin
                cnt_d = cnt_q + 5'd1;
                if (is_read_q) begin
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = StRdData;
                end else if (cnt_q == 5'd1) begin
                    cnt_d   = '0;
                    state_d = StWrData;
                end
            end
            StRdData: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd16) begin
                    mdio_oe_d = 1'b0;
                    mdio_o_d  = 1'b1;
                    state_d   = StIdle;
                end else begin
                    mdio_o_d = shift_q[15];
                    shift_d  = {shift_q[14:0], 1'b0};
                end
            end
            StWrData: begin
                shift_d = wdata;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = reg_addr_q;
                    wr_data_d   = wdata;
                    state_d     = StIdle;
                    if (reg_addr_q == 5'd0) begin
                        reg_we     = 1'b1;
                        soft_rst_d = wdata[15];
                        reg_wval   = wdata[15] ? REG0_RST : wdata;
                    end else if (reg_addr_q > 5'd3) begin
                        reg_we = 1'b1;
                    end
                end
            end
            StSkip: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd17) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pre_q       <= '0;
            shift_q     <= '0;
            is_read_q   <= 1'b0;
            phy_match_q <= 1'b0;
            reg_addr_q  <= '0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            soft_rst_q  <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= (i == 0) ? REG0_RST : 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            shift_q     <= shift_d;
            is_read_q   <= is_read_d;
            phy_match_q <= phy_match_d;
            reg_addr_q  <= reg_addr_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            soft_rst_q  <= soft_rst_d;
            if (reg_we) regs_q[reg_addr_q] <= reg_wval;
        end
    end

    assign bus.mdio_o     = mdio_o_q;
    assign bus.mdio_oe    = mdio_oe_q;
    assign bus.ctrl_o     = regs_q[0];
    assign bus.wr_strobe  = wr_strobe_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.soft_rst_o = soft_rst_q;
endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: acts as the MDIO controller, scoreboarding expected read data
// and expected write side-band activity in queues popped when the responder produces them.
module tb_mdio_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mdio_responder_if bus ();

    mdio_responder #(
        .PHY_ADDR    (5'd1),
        .PREAMBLE_LEN(32),
        .REG0_RST    (16'h3100),
        .PHY_ID1     (16'h0022),
        .PHY_ID2     (16'h1550)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rd_q [$];
    logic [21:0] wr_q [$];  // {soft_rst, addr, data}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b);
        @(negedge clk);
        bus.mdio_i = b;
    endtask

    task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                               input logic [4:0] ra);
        logic [13:0] hdr;
        hdr = {2'b01, op, phy, ra};
        drive(1'b0);  // clears any idle-ones run left over from the previous frame
        for (int i = 0; i < pre; i++) drive(1'b1);
        for (int i = 13; i >= 0; i--) drive(hdr[i]);
    endtask

    task automatic watch_strobe();
        logic [21:0] e;
        if (bus.wr_strobe) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr_strobe", 32'(bus.wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e[20:16]));
                check("wr_data", 32'(bus.wr_data), 32'(e[15:0]));
                check("soft_rst_with_strobe", 32'(bus.soft_rst_o), 32'(e[21]));
            end
        end else if (bus.soft_rst_o) begin
            check("soft_rst_stray", 32'(bus.soft_rst_o), 32'd0);
        end
    endtask

    task automatic frame(input string tag, input int pre, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                         input int exp_oe, input int exp_stb);
        logic [15:0] rd;
        int          oe_n;
        int          stb_n;
        logic        ta2;
        send_header(pre, op, phy, ra);
        rd = '0; oe_n = 0; stb_n = 0; ta2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mdio_oe) oe_n++;
            if (i == 1) ta2 = bus.mdio_oe ? bus.mdio_o : 1'b1;
            if (i >= 2 && i <= 17) rd = {rd[14:0], bus.mdio_o};
            if (bus.wr_strobe) stb_n++;
            watch_strobe();
            if (op == 2'b01 && i < 18) bus.mdio_i = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : wd[17-i];
            else bus.mdio_i = 1'b1;
        end
        check({tag, "_oe_cycles"}, 32'(oe_n), 32'(exp_oe));
        check({tag, "_strobes"}, 32'(stb_n), 32'(exp_stb));
        if (exp_oe == 17) begin
            check({tag, "_ta2"}, 32'(ta2), 32'd0);
            if (rd_q.size() == 0) check({tag, "_no_expect"}, 32'(rd), 32'hFFFF_FFFF);
            else check({tag, "_rdata"}, 32'(rd), 32'(rd_q.pop_front()));
        end
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] ra, input logic [15:0] exp);
        rd_q.push_back(exp);
        frame(tag, 32, 2'b10, 5'd1, ra, 16'h0000, 17, 0);
    endtask

    task automatic wr_reg(input string tag, input logic [4:0] ra, input logic [15:0] d);
        wr_q.push_back({(ra == 5'd0) && d[15], ra, d});
        frame(tag, 32, 2'b01, 5'd1, ra, d, 0, 1);
    endtask

    // Reset lands while data bit 8 is on the line (edge N+9 of the frame).
    task automatic abort(input string tag, input logic [1:0] op, input logic [4:0] ra,
                         input logic [15:0] wd);
        int stb_n;
        send_header(32, op, 5'd1, ra);
        stb_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.wr_strobe) stb_n++;
            if (op == 2'b01) bus.mdio_i = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : wd[17-i];
            else bus.mdio_i = 1'b1;
        end
        if (op == 2'b10) check({tag, "_oe_before_rst"}, 32'(bus.mdio_oe), 32'd1);
        rst = 1'b1;
        #1;
        check({tag, "_oe_in_rst"}, 32'(bus.mdio_oe), 32'd0);
        check({tag, "_o_in_rst"}, 32'(bus.mdio_o), 32'd1);
        bus.mdio_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.wr_strobe) stb_n++;
            bus.mdio_i = wd[i];
        end
        check({tag, "_no_strobe"}, 32'(stb_n), 32'd0);
        check({tag, "_ctrl_after_rst"}, 32'(bus.ctrl_o), 32'h3100);
        bus.mdio_i = 1'b0;
    endtask

    initial begin
        bus.mdio_i   = 1'b0;
        bus.status_i = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_oe", 32'(bus.mdio_oe), 32'd0);
        check("rst_o", 32'(bus.mdio_o), 32'd1);
        check("rst_strobe", 32'(bus.wr_strobe), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_soft", 32'(bus.soft_rst_o), 32'd0);
        check("rst_ctrl", 32'(bus.ctrl_o), 32'h3100);

        wr_reg("wr4", 5'd4, 16'hA5C3);
        rd_reg("rd4", 5'd4, 16'hA5C3);
        rd_reg("rd_id1", 5'd2, 16'h0022);
        rd_reg("rd_id2", 5'd3, 16'h1550);
        wr_reg("wr_ro2", 5'd2, 16'hFFFF);
        rd_reg("rd_id1_again", 5'd2, 16'h0022);
        bus.status_i = 16'h782D;
        rd_reg("rd_status", 5'd1, 16'h782D);
        wr_reg("wr0_softrst", 5'd0, 16'h8000);
        check("ctrl_after_softrst", 32'(bus.ctrl_o), 32'h3100);
        wr_reg("wr0", 5'd0, 16'h1140);
        check("ctrl_after_wr", 32'(bus.ctrl_o), 32'h1140);
        rd_reg("rd0", 5'd0, 16'h1140);
        wr_reg("wr31", 5'd31, 16'h5A0F);
        rd_reg("rd31", 5'd31, 16'h5A0F);

        frame("wr_other_phy", 32, 2'b01, 5'd5, 5'd4, 16'h1234, 0, 0);
        frame("rd_other_phy", 32, 2'b10, 5'd5, 5'd4, 16'h0000, 0, 0);
        rd_reg("rd4_unchanged", 5'd4, 16'hA5C3);
        frame("short_pre", 31, 2'b01, 5'd1, 5'd4, 16'h0F0F, 0, 0);
        rd_reg("rd4_after_short", 5'd4, 16'hA5C3);
        frame("op11", 32, 2'b11, 5'd1, 5'd4, 16'h0000, 0, 0);
        rd_reg("rd_after_op11", 5'd2, 16'h0022);

        abort("abort_rd", 2'b10, 5'd4, 16'h0000);
        abort("abort_wr", 2'b01, 5'd5, 16'hBEEF);
        rd_reg("rd4_post_rst", 5'd4, 16'h0000);
        rd_reg("rd5_post_rst", 5'd5, 16'h0000);

        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
